// File: rtl/my_mux_pkg.sv
// Shared types and default sizing for the N-to-1 arbitrating mux.
package my_mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_N     = 8;

endpackage

// File: rtl/my_rr_arbiter.sv
// N-way arbiter: round-robin from a rotating pointer, or fixed lowest-index priority.
module my_rr_arbiter
  import my_mux_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter arb_mode_e   MODE = ARB_RR,
  localparam int unsigned SW  = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] start;
  logic [SW:0]   probe;
  logic          found;

  // Scan from the start index with wrap; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    probe     = '0;
    start     = (MODE == ARB_RR) ? ptr_q : '0;
    for (int unsigned i = 0; i < N; i++) begin
      probe = {1'b0, start} + (SW+1)'(i);
      if (probe >= (SW+1)'(N)) probe = probe - (SW+1)'(N);
      if (!found && req[probe[SW-1:0]]) begin
        found     = 1'b1;
        grant_idx = probe[SW-1:0];
      end
    end
    grant[grant_idx] = found;
  end

  // Pointer moves past the winner on each accepted beat; parked at 0 in fixed mode.
  always_comb begin
    ptr_d = ptr_q;
    if (MODE == ARB_RR && advance) begin
      ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/my_arb_muxn.sv
// N-to-1 arbitrating mux with a single registered valid/ready output stage.
module my_arb_muxn
  import my_mux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N     = DEF_N,
  parameter arb_mode_e   MODE  = ARB_RR,
  localparam int unsigned SW   = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0][WIDTH-1:0] in_data,
  input  logic [N-1:0]          in_valid,
  output logic [N-1:0]          in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SW-1:0]         out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  if (N < 2 || N > 32 || WIDTH < 1 || WIDTH > 64) begin : g_param_check
    $error("my_arb_muxn: N must be 2..32 and WIDTH 1..64");
  end

  logic [N-1:0]     grant;
  logic [SW-1:0]    grant_idx;
  logic             load_c;
  logic             accept_c;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  assign load_c   = !out_valid_q || out_ready;
  assign accept_c = load_c && rst_n && (|grant);
  assign in_ready = (load_c && rst_n) ? grant : '0;

  my_rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (accept_c),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Only the winner's slice is muxed in; idle loads drop valid but keep data/sel.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_c) begin
      out_valid_d = |grant;
      if (|grant) begin
        out_data_d = in_data[grant_idx];
        out_sel_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_my_arb_muxn.sv
// Directed bench: RR and fixed-priority instances driven from shared inputs.
module tb_my_arb_muxn;
  import my_mux_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned NC = 8;

  logic                 clk;
  logic                 rst_n;
  logic [NC-1:0][W-1:0] in_data;
  logic [NC-1:0]        in_valid;
  logic                 out_ready;

  logic [NC-1:0] rdy_rr, rdy_fx;
  logic [W-1:0]  data_rr, data_fx;
  logic [2:0]    sel_rr, sel_fx;
  logic          ov_rr, ov_fx;

  int checks;
  int errors;

  logic [W-1:0] chan_data [NC];

  typedef struct {
    logic [7:0] v;
    logic       ordy;
    logic [7:0] rdy;
    logic       ov;
    logic [2:0] sel;
    logic [2:0] p;
  } vec_t;

  localparam int NV = 25;
  vec_t vec [NV];

  my_arb_muxn #(.WIDTH(W), .N(NC), .MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_rr), .out_data(data_rr), .out_sel(sel_rr),
    .out_valid(ov_rr), .out_ready(out_ready)
  );

  my_arb_muxn #(.WIDTH(W), .N(NC), .MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_fx), .out_data(data_fx), .out_sel(sel_fx),
    .out_valid(ov_fx), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < NC; k++) chan_data[k] = W'(16'h1000 + k);
    chan_data[3] = 16'hBEEF;
    for (int k = 0; k < NC; k++) in_data[k] = chan_data[k];

    //        v      ordy  rdy    ov    sel   p
    vec[0]  = '{8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 3'd1};
    vec[1]  = '{8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 3'd2};
    vec[2]  = '{8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 3'd3};
    vec[3]  = '{8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 3'd4};
    vec[4]  = '{8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 3'd5};
    vec[5]  = '{8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 3'd6};
    vec[6]  = '{8'hFF, 1'b1, 8'h40, 1'b1, 3'd6, 3'd7};
    vec[7]  = '{8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 3'd0};
    vec[8]  = '{8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 3'd1};
    vec[9]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 3'd1};
    vec[10] = '{8'h20, 1'b1, 8'h20, 1'b1, 3'd5, 3'd6};
    vec[11] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 3'd6};
    vec[12] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd5, 3'd6};
    vec[13] = '{8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 3'd4};
    vec[14] = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 3'd4};
    vec[15] = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 3'd4};
    vec[16] = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd3, 3'd4};
    vec[17] = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 3'd4};
    vec[18] = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 3'd4};
    vec[19] = '{8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 3'd5};
    vec[20] = '{8'h40, 1'b1, 8'h40, 1'b1, 3'd6, 3'd7};
    vec[21] = '{8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 3'd0};
    vec[22] = '{8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 3'd1};
    vec[23] = '{8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 3'd0};
    vec[24] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd7, 3'd0};

    rst_n     = 1'b0;
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    #1;
    chk("rst_ov",    0, 64'(ov_rr),   64'd0);
    chk("rst_data",  0, 64'(data_rr), 64'd0);
    chk("rst_sel",   0, 64'(sel_rr),  64'd0);
    chk("rst_ready", 0, 64'(rdy_rr),  64'd0);
    chk("rst_ready_fx", 0, 64'(rdy_fx), 64'd0);
    in_valid = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RR vectors: in_ready before the edge, registered outputs and pointer after.
    for (int i = 0; i < NV; i++) begin
      in_valid  = vec[i].v;
      out_ready = vec[i].ordy;
      #1;
      chk("rr_in_ready", i, 64'(rdy_rr), 64'(vec[i].rdy));
      @(posedge clk);
      #1;
      chk("rr_out_valid", i, 64'(ov_rr),   64'(vec[i].ov));
      chk("rr_out_sel",   i, 64'(sel_rr),  64'(vec[i].sel));
      chk("rr_out_data",  i, 64'(data_rr), 64'(chan_data[vec[i].sel]));
      chk("rr_ptr",       i, 64'(dut_rr.u_arb.ptr_q), 64'(vec[i].p));
    end

    // Fixed priority: lowest requester always wins, pointer stays parked.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 8'b1010_0100;
      out_ready = 1'b1;
      #1;
      chk("fx_in_ready", i, 64'(rdy_fx), 64'h04);
      @(posedge clk);
      #1;
      chk("fx_out_valid", i, 64'(ov_fx),   64'd1);
      chk("fx_out_sel",   i, 64'(sel_fx),  64'd2);
      chk("fx_out_data",  i, 64'(data_fx), 64'h1002);
      chk("fx_ptr",       i, 64'(dut_fx.u_arb.ptr_q), 64'd0);
    end
    out_ready = 1'b0;
    #1;
    chk("fx_bp_ready", 0, 64'(rdy_fx), 64'h00);
    @(posedge clk);
    #1;
    chk("fx_bp_sel",   0, 64'(sel_fx), 64'd2);
    chk("fx_bp_valid", 0, 64'(ov_fx),  64'd1);
    chk("rr_pre_rst_valid", 0, 64'(ov_rr), 64'd1);

    // Asynchronous reset mid-cycle with a beat held in both output registers.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov_rr",   0, 64'(ov_rr),   64'd0);
    chk("arst_data_rr", 0, 64'(data_rr), 64'd0);
    chk("arst_sel_rr",  0, 64'(sel_rr),  64'd0);
    chk("arst_rdy_rr",  0, 64'(rdy_rr),  64'd0);
    chk("arst_ptr_rr",  0, 64'(dut_rr.u_arb.ptr_q), 64'd0);
    chk("arst_ov_fx",   0, 64'(ov_fx),   64'd0);
    chk("arst_data_fx", 0, 64'(data_fx), 64'd0);
    chk("arst_rdy_fx",  0, 64'(rdy_fx),  64'd0);

    // After release channel 0 has top priority in both modes.
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    #1;
    chk("post_rst_rdy_rr", 0, 64'(rdy_rr), 64'h01);
    chk("post_rst_rdy_fx", 0, 64'(rdy_fx), 64'h01);
    @(posedge clk);
    #1;
    chk("post_rst_sel_rr",  0, 64'(sel_rr),  64'd0);
    chk("post_rst_data_rr", 0, 64'(data_rr), 64'h1000);
    chk("post_rst_sel_fx",  0, 64'(sel_fx),  64'd0);
    chk("post_rst_ov_fx",   0, 64'(ov_fx),   64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/my_arb_muxn.md
MY_ARB_MUXN -- requirements
Module: my_arb_muxn

Interface
REQ-001 Parameter WIDTH, default 16, data width per channel; legal range 1..64.
REQ-002 Parameter N, default 8, channel count; legal range 2..32; SW = $clog2(N).
REQ-003 Parameter MODE, default ARB_RR, arbitration mode; legal values ARB_RR (round-robin) and ARB_FIXED (lowest index wins).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  N x WIDTH  per-channel data; channel k in slice k.
REQ-007 in_valid  input  N  per-channel request.
REQ-008 in_ready  output  N  per-channel accept; one-hot or zero.
REQ-009 out_data  output  WIDTH  registered selected data.
REQ-010 out_sel  output  SW  registered index of the channel that supplied out_data.
REQ-011 out_valid  output  1  out_data/out_sel hold a valid beat.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 Transfer on a channel k SHALL occur when in_valid[k] && in_ready[k] in the same cycle; transfer on the output SHALL occur when out_valid && out_ready.
REQ-014 load = !out_valid || out_ready; this signal SHALL gate every input acceptance.
REQ-015 in_ready SHALL be combinational: in_ready[g] = 1 only for the arbitration winner g and only when load = 1; otherwise all zero.
REQ-016 Under ARB_FIXED, the winner SHALL be the lowest index k with in_valid[k] = 1.
REQ-017 Under ARB_RR, the search SHALL start at pointer p and proceed p, p+1, ... wrapping at N-1 to 0; the first valid channel wins.
REQ-018 Pointer p (SW bits) SHALL update to (g+1) mod N on each input transfer; if g = N-1 then p SHALL become 0.
REQ-019 Pointer p SHALL hold on cycles without an input transfer; it SHALL be unused under ARB_FIXED.
REQ-020 On input transfer, the block SHALL register out_data <= in_data[g], out_sel <= g and out_valid <= 1 at the next edge; latency SHALL be exactly 1 cycle.
REQ-021 When load = 1 with no in_valid set, out_valid SHALL go to 0 at the next edge; out_data and out_sel SHALL hold their values.
REQ-022 While out_valid && !out_ready, the output registers SHALL remain stable and in_ready SHALL be all zero.
REQ-023 Simultaneous output drain and new input accept in one cycle SHALL sustain 1 beat per cycle with no bubble.
REQ-024 No beat SHALL be dropped or duplicated; an input beat SHALL be accepted only once.
REQ-025 The block SHALL not depend on in_data of non-winning channels, and SHALL propagate no X onto out_data from unused channels.

Reset
REQ-026 Asserting rst_n low SHALL immediately force out_valid = 0, out_data = 0, out_sel = 0 and p = 0, independent of clk.
REQ-027 During reset, in_ready SHALL be all zero; a beat in the output register mid-transfer SHALL be discarded.
REQ-028 On the first rising edge after rst_n deasserts, channel 0 SHALL have the highest priority in both modes.

Structure
REQ-029 Package my_mux_pkg SHALL hold the arb_mode_e enum (ARB_RR, ARB_FIXED) and the default WIDTH/N constants.
REQ-030 The arbitration logic SHALL be a separate sub-module, my_rr_arbiter (parameters N and MODE; ports: req, ptr, advance, grant one-hot, grant index, pointer register). my_arb_muxn SHALL contain the data path and output register.
REQ-031 Elaboration SHALL fail with an error for N < 2 or WIDTH < 1.

Verification
REQ-032 Reset: hold rst_n = 0 mid-stream with out_valid = 1 -> out_valid, out_data and out_sel read 0 before the next clk edge, and in_ready reads 0.
REQ-033 RR fairness: N = 8, all in_valid = 1, out_ready = 1, data[k] = 16'h1000+k -> out_sel sequence 0,1,...,7,0 on consecutive cycles, with no bubbles.
REQ-034 Fixed priority: MODE = ARB_FIXED, in_valid = 8'b1010_0100 held -> every beat has out_sel = 2; in_ready = 8'b0000_0100.
REQ-035 Backpressure: out_ready = 0 for 5 cycles after a beat from channel 3 (data 16'hBEEF) -> out_data stays 16'hBEEF, out_sel stays 3, in_ready stays 0, p stays 4; release -> next winner is searched from channel 4.
REQ-036 Wrap: p = 7, in_valid = 8'b1000_0001 -> channel 7 wins, then channel 0, with p going 7 -> 0 -> 1.
REQ-037 Idle drain: single beat from channel 5, then in_valid = 0 and out_ready = 1 -> out_valid is 1 for exactly one cycle, and out_data/out_sel hold afterwards.
